// File: rtl/matmul_pkg.sv
// Shared constants for the matrix-multiplication datapath.
// Used by the MAC stage and the downstream 18-bit adder stage.
package matmul_pkg;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 18;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int LEN_MIN = 1;
  localparam int LEN_MAX = 16;
  localparam int CNT_W   = $clog2(LEN_MAX);
endpackage

// File: rtl/dot_product_mac_if.sv
// Element-pair input and dot-product output handshakes.
// master drives pairs and consumes results; slave is the MAC.
interface dot_product_mac_if;
  import matmul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/dot_product_mac_elem_mul.sv
// elem_mul: registered unsigned element multiplier with hold.
// Carries the term's valid and last flags alongside the product.
module elem_mul
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              vld,
  input  logic              last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p,
  output logic              p_valid,
  output logic              p_last
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  assign a_ext = {{(PROD_W-DATA_W){1'b0}}, a};
  assign b_ext = {{(PROD_W-DATA_W){1'b0}}, b};

  // Product register; holds everything while the MAC is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p       <= a_ext * b_ext;
      p_valid <= vld;
      p_last  <= last;
    end
  end

endmodule

// File: rtl/dot_product_mac.sv
// dot_product_mac: streaming multiply-accumulate of LEN pairs.
// Optional `SATURATE_EN clamps sums on overflow instead of wrapping.
module dot_product_mac
  import matmul_pkg::*;
#(
  parameter int LEN = 4
) (
  input logic              clk,
  input logic              rst_n,
  dot_product_mac_if.slave bus
);

  if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_len_bad
    $error("dot_product_mac: LEN out of range");
  end

  logic [CNT_W-1:0]  cnt;
  logic              last_term;
  logic              in_xfer;
  logic              stall;

  logic [PROD_W-1:0] p;
  logic              p_valid;
  logic              p_last;

  logic [ACC_W-1:0]  acc;
  logic              ovf_acc;
  logic              first;
  logic              acc_en;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum;
  logic              ovf_now;
  logic [ACC_W-1:0]  acc_nxt;

  logic              out_valid;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  assign stall     = p_valid && p_last && out_valid && !bus.out_ready;
  assign in_xfer   = bus.in_valid && !stall;
  assign last_term = (cnt == CNT_W'(LEN - 1));

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_ovf   = out_ovf;

  // Term position within the current vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_xfer) begin
      cnt <= last_term ? '0 : cnt + 1'b1;
    end
  end

  elem_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (!stall),
    .vld     (in_xfer),
    .last    (last_term),
    .a       (bus.a_in),
    .b       (bus.b_in),
    .p       (p),
    .p_valid (p_valid),
    .p_last  (p_last)
  );

  assign acc_en  = p_valid && !stall;
  assign base    = first ? '0 : acc;
  assign sum     = {1'b0, base}
                 + {{(ACC_W+1-PROD_W){1'b0}}, p};
  assign ovf_now = ovf_acc | sum[ACC_W];

`ifdef SATURATE_EN
  assign acc_nxt = ovf_now ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  // Running sum of the vector in flight; cleared on its last term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      first   <= 1'b1;
    end else if (acc_en) begin
      if (p_last) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
        first   <= 1'b1;
      end else begin
        acc     <= acc_nxt;
        ovf_acc <= ovf_now;
        first   <= 1'b0;
      end
    end
  end

  // Result register; a new load wins over a same-cycle unload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (acc_en && p_last) begin
      out_valid <= 1'b1;
      out_sum   <= acc_nxt;
      out_ovf   <= ovf_now;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac at LEN 4, 5 and 1.
// Expected sums are hand-computed; honours `SATURATE_EN.
module tb_dot_product_mac;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dot_product_mac_if if4 ();
  dot_product_mac_if if5 ();
  dot_product_mac_if if1 ();

  dot_product_mac #(.LEN(4)) u_mac4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  dot_product_mac #(.LEN(5)) u_mac5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if5.slave)
  );

  dot_product_mac #(.LEN(1)) u_mac1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    int               cyc;
  } res_t;

  res_t q4[$];
  res_t q5[$];
  res_t q1[$];

  always @(negedge clk) begin
    if (if4.out_valid && if4.out_ready)
      q4.push_back('{if4.out_sum, if4.out_ovf, cyc});
    if (if5.out_valid && if5.out_ready)
      q5.push_back('{if5.out_sum, if5.out_ovf, cyc});
    if (if1.out_valid && if1.out_ready)
      q1.push_back('{if1.out_sum, if1.out_ovf, cyc});
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(int d);
    case (d)
      4:       return if4.in_ready;
      5:       return if5.in_ready;
      default: return if1.in_ready;
    endcase
  endfunction

  function automatic int qsize(int d);
    case (d)
      4:       return q4.size();
      5:       return q5.size();
      default: return q1.size();
    endcase
  endfunction

  task automatic set_in(int d, logic v, logic [7:0] a,
                        logic [7:0] b);
    case (d)
      4: begin
        if4.in_valid = v; if4.a_in = a; if4.b_in = b;
      end
      5: begin
        if5.in_valid = v; if5.a_in = a; if5.b_in = b;
      end
      default: begin
        if1.in_valid = v; if1.a_in = a; if1.b_in = b;
      end
    endcase
  endtask

  // Present a pair; returns after the edge that accepts it.
  task automatic send(int d, logic [7:0] a, logic [7:0] b,
                      output int tries);
    logic r;
    tries = 0;
    set_in(d, 1'b1, a, b);
    do begin
      @(negedge clk);
      r = rdy(d);
      @(posedge clk);
      #1;
      tries++;
    end while (!r && tries < 50);
    if (!r) check("send_timeout", 0, 1);
    set_in(d, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic wait_res(int d, int n);
    int t = 0;
    while (qsize(d) < n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (qsize(d) < n) check("result_timeout", qsize(d), n);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] exp5;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];

    set_in(4, 1'b0, 8'd0, 8'd0);
    set_in(5, 1'b0, 8'd0, 8'd0);
    set_in(1, 1'b0, 8'd0, 8'd0);
    if4.out_ready = 1'b1;
    if5.out_ready = 1'b1;
    if1.out_ready = 1'b1;

    rst_n = 1'b0;
    step(3);
    check("rst_in_ready", if4.in_ready, 1);
    check("rst_out_valid", if4.out_valid, 0);
    check("rst_out_sum", if4.out_sum, 0);
    check("rst_out_ovf", if4.out_ovf, 0);
    rst_n = 1'b1;

    // Basic vector, latency and single-cycle out_valid
    a_v = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_v = '{8'd5, 8'd6, 8'd7, 8'd8};
    q4.delete();
    for (int i = 0; i < 4; i++) send(4, a_v[i], b_v[i], t);
    check("t1_valid_early", if4.out_valid, 0);
    step(1);
    check("t1_valid", if4.out_valid, 1);
    check("t1_sum", if4.out_sum, 70);
    check("t1_ovf", if4.out_ovf, 0);
    step(1);
    check("t1_valid_drop", if4.out_valid, 0);

    // Two vectors back to back, no bubbles
    q4.delete();
    for (int i = 0; i < 4; i++) begin
      send(4, 8'd255, 8'd255, t);
      check("t2_ready_a", t, 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(4, 8'd1, 8'd1, t);
      check("t2_ready_b", t, 1);
    end
    wait_res(4, 2);
    if (q4.size() >= 2) begin
      check("t2_sum0", q4[0].sum, 260100);
      check("t2_ovf0", q4[0].ovf, 0);
      check("t2_sum1", q4[1].sum, 4);
      check("t2_slot", q4[1].cyc - q4[0].cyc, 4);
    end
    step(2);

    // Overflow at LEN=5
`ifdef SATURATE_EN
    exp5 = 262143;
`else
    exp5 = 62981;
`endif
    q5.delete();
    for (int i = 0; i < 5; i++) send(5, 8'd255, 8'd255, t);
    wait_res(5, 1);
    if (q5.size() >= 1) begin
      check("t3_sum", q5[0].sum, exp5);
      check("t3_ovf", q5[0].ovf, 1);
    end
    step(2);

    // Back-pressure with a result pending
    if4.out_ready = 1'b0;
    q4.delete();
    for (int i = 0; i < 4; i++)
      send(4, 8'd1, 8'(i + 1), t);
    step(2);
    check("t4_pend_valid", if4.out_valid, 1);
    check("t4_pend_sum", if4.out_sum, 10);
    for (int i = 0; i < 4; i++) begin
      send(4, 8'd2, 8'd2, t);
      check("t4_ready_b", t, 1);
    end
    check("t4_stall", if4.in_ready, 0);
    check("t4_hold_sum", if4.out_sum, 10);
    step(3);
    check("t4_stall_long", if4.in_ready, 0);
    check("t4_hold_valid", if4.out_valid, 1);
    check("t4_hold_sum2", if4.out_sum, 10);
    if4.out_ready = 1'b1;
    wait_res(4, 2);
    if (q4.size() >= 2) begin
      check("t4_first", q4[0].sum, 10);
      check("t4_second", q4[1].sum, 16);
      check("t4_back2back", q4[1].cyc - q4[0].cyc, 1);
    end
    check("t4_ready_back", if4.in_ready, 1);

    // Reset mid-vector discards the partial sum
    q4.delete();
    send(4, 8'd9, 8'd9, t);
    send(4, 8'd9, 8'd9, t);
    rst_n = 1'b0;
    step(1);
    check("t5_rst_ready", if4.in_ready, 1);
    check("t5_rst_valid", if4.out_valid, 0);
    check("t5_rst_sum", if4.out_sum, 0);
    check("t5_rst_ovf", if4.out_ovf, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(4, 8'd1, 8'd1, t);
    wait_res(4, 1);
    if (q4.size() >= 1) begin
      check("t5_sum", q4[0].sum, 4);
      check("t5_count", q4.size(), 1);
    end
    step(2);

    // LEN=1: one result per pair
    q1.delete();
    send(1, 8'd3, 8'd3, t);
    send(1, 8'd0, 8'd9, t);
    send(1, 8'd255, 8'd2, t);
    wait_res(1, 3);
    if (q1.size() >= 3) begin
      check("t6_sum0", q1[0].sum, 9);
      check("t6_sum1", q1[1].sum, 0);
      check("t6_sum2", q1[2].sum, 510);
      check("t6_ovf2", q1[2].ovf, 0);
      check("t6_gap01", q1[1].cyc - q1[0].cyc, 1);
      check("t6_gap12", q1[2].cyc - q1[1].cyc, 1);
    end
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
